// File: rtl/ann_pkg.sv
// Shared ANN definitions: request encodings, loader FSM states and the
// network dimensions used by both the loader and the datapath.
package ann_pkg;

    localparam int IMAGE_SIZE  = 64;
    localparam int FIRST_LAYER = 16;

    typedef enum logic [1:0] {
        WD_IMAGE   = 2'b00,
        WD_WEIGHTS = 2'b01,
        WD_BOTH    = 2'b10
    } which_data_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/coef_read_master.sv
// Single-outstanding read master: holds the address through waitrequest and
// hands each returned word to the packer as a one-cycle strobe.
module coef_read_master
    import ann_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              mem_waitrequest,
    input  logic              mem_readdatavalid,
    input  logic [15:0]       mem_readdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              word_valid,
    output logic [15:0]       word_data,
    output fetch_state_e      state
);

    fetch_state_e      state_r;
    logic [ADDR_W-1:0] mem_address_r;
    logic              mem_read_r;

    assign mem_address = mem_address_r;
    assign mem_read    = mem_read_r;
    assign state       = state_r;

    // Returned data is only meaningful while a read is outstanding.
    always_comb begin
        word_data = mem_readdata;
        if (state_r == ST_WAIT) begin
            word_valid = mem_readdatavalid;
        end else begin
            word_valid = 1'b0;
        end
    end

    // Handshake FSM; a follow-on request in WAIT chains straight into ISSUE.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_r       <= ST_IDLE;
            mem_address_r <= '0;
            mem_read_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req) begin
                        state_r       <= ST_ISSUE;
                        mem_read_r    <= 1'b1;
                        mem_address_r <= req_addr;
                    end
                end
                ST_ISSUE: begin
                    if (!mem_waitrequest) begin
                        state_r    <= ST_WAIT;
                        mem_read_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (mem_readdatavalid) begin
                        if (req) begin
                            state_r       <= ST_ISSUE;
                            mem_read_r    <= 1'b1;
                            mem_address_r <= req_addr;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    mem_read_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/coef_fetch.sv
// Image / first-layer weight loader: walks the word addresses, packs returned
// words into the flat buses and holds busy until the last word lands.
module coef_fetch
    import ann_pkg::*;
#(
    parameter int                IMAGE_SIZE  = ann_pkg::IMAGE_SIZE,
    parameter int                FIRST_LAYER = ann_pkg::FIRST_LAYER,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] IMAGE_BASE  = 16'h0000,
    parameter logic [ADDR_W-1:0] WEIGHT_BASE = 16'h4000
) (
    input  logic                                clk,
    input  logic                                n_reset,
    input  logic                                get_data,
    input  logic [1:0]                          which_data,
    input  logic [9:0]                          image_address,
    output logic [ADDR_W-1:0]                   mem_address,
    output logic                                mem_read,
    input  logic                                mem_waitrequest,
    input  logic                                mem_readdatavalid,
    input  logic [15:0]                         mem_readdata,
    output logic [IMAGE_SIZE*16-1:0]            image_data,
    output logic [FIRST_LAYER*IMAGE_SIZE*16-1:0] coeff_data,
    output logic                                busy
);

    localparam int CNT_W = $clog2(FIRST_LAYER * IMAGE_SIZE);
    localparam int IMG_W = $clog2(IMAGE_SIZE);

    logic [CNT_W-1:0]                     count_r;
    logic                                 phase_wt_r;
    logic                                 both_r;
    logic [ADDR_W-1:0]                    image_base_r;
    logic                                 busy_r;
    logic [IMAGE_SIZE*16-1:0]             image_data_r;
    logic [FIRST_LAYER*IMAGE_SIZE*16-1:0] coeff_data_r;

    logic              start_s;
    logic              last_s;
    logic              more_s;
    logic              req_s;
    logic              word_s;
    logic              next_phase_s;
    logic [CNT_W-1:0]  next_count_s;
    logic [ADDR_W-1:0] image_base_s;
    logic [ADDR_W-1:0] req_addr_s;
    logic [15:0]       word_data_s;
    fetch_state_e      state_s;

    assign busy       = busy_r;
    assign image_data = image_data_r;
    assign coeff_data = coeff_data_r;

    // Next request: either the first word of a new load or the word after the
    // one just returned (crossing from image to weights in the combined mode).
    always_comb begin
        image_base_s = IMAGE_BASE + ADDR_W'(32'(image_address) * 32'(IMAGE_SIZE));
        start_s      = 1'b0;
        if ((state_s == ST_IDLE) && get_data && (which_data != 2'b11)) begin
            start_s = 1'b1;
        end else begin
            start_s = 1'b0;
        end
        if (phase_wt_r) begin
            last_s = (count_r == CNT_W'(FIRST_LAYER * IMAGE_SIZE - 1));
        end else begin
            last_s = (count_r == CNT_W'(IMAGE_SIZE - 1));
        end
        more_s = word_s && (!last_s || (!phase_wt_r && both_r));
        if (last_s) begin
            next_count_s = '0;
            next_phase_s = 1'b1;
        end else begin
            next_count_s = count_r + CNT_W'(1);
            next_phase_s = phase_wt_r;
        end
        req_s = start_s || more_s;
        if (start_s) begin
            if (which_data == WD_WEIGHTS) begin
                req_addr_s = WEIGHT_BASE;
            end else begin
                req_addr_s = image_base_s;
            end
        end else if (next_phase_s) begin
            req_addr_s = WEIGHT_BASE + ADDR_W'(next_count_s);
        end else begin
            req_addr_s = image_base_r + ADDR_W'(next_count_s);
        end
    end

    coef_read_master #(
        .ADDR_W (ADDR_W)
    ) u_master (
        .clk               (clk),
        .n_reset           (n_reset),
        .req               (req_s),
        .req_addr          (req_addr_s),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .word_valid        (word_s),
        .word_data         (word_data_s),
        .state             (state_s)
    );

    // Load bookkeeping and packing; untouched slots keep their old contents.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count_r      <= '0;
            phase_wt_r   <= 1'b0;
            both_r       <= 1'b0;
            image_base_r <= '0;
            busy_r       <= 1'b0;
            image_data_r <= '0;
            coeff_data_r <= '0;
        end else begin
            if (start_s) begin
                busy_r       <= 1'b1;
                count_r      <= '0;
                phase_wt_r   <= (which_data == WD_WEIGHTS);
                both_r       <= (which_data == WD_BOTH);
                image_base_r <= image_base_s;
            end else if (word_s) begin
                if (phase_wt_r) begin
                    coeff_data_r[{count_r, 4'b0000} +: 16] <= word_data_s;
                end else begin
                    image_data_r[{count_r[IMG_W-1:0], 4'b0000} +: 16] <= word_data_s;
                end
                if (more_s) begin
                    count_r    <= next_count_s;
                    phase_wt_r <= next_phase_s;
                end else begin
                    count_r <= '0;
                    busy_r  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_coef_fetch.sv
// Bench for coef_fetch: a memory responder with configurable stall/latency,
// a word-array reference model, table-driven loads and random loads.
module tb_coef_fetch;
    import ann_pkg::*;

    localparam int IS    = 64;
    localparam int FL    = 16;
    localparam int NW    = IS * FL;
    localparam int LIMIT = 20000;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic              get_data = 1'b0;
    logic [1:0]        which_data = 2'b00;
    logic [9:0]        image_address = 10'd0;
    logic [15:0]       mem_address;
    logic              mem_read;
    logic              mem_waitrequest = 1'b0;
    logic              mem_readdatavalid = 1'b0;
    logic [15:0]       mem_readdata = 16'h0000;
    logic [IS*16-1:0]  image_data;
    logic [NW*16-1:0]  coeff_data;
    logic              busy;

    coef_fetch dut (
        .clk               (clk),
        .n_reset           (n_reset),
        .get_data          (get_data),
        .which_data        (which_data),
        .image_address     (image_address),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdatavalid (mem_readdatavalid),
        .mem_readdata      (mem_readdata),
        .image_data        (image_data),
        .coeff_data        (coeff_data),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // responder configuration (written by the test, read by the responder)
    int          stall_cfg = 0;
    int          lat_cfg   = 0;
    logic [15:0] off_cfg   = 16'h0000;
    logic [15:0] xor_cfg   = 16'h0000;
    bit          spur_en   = 1'b0;

    // responder state
    bit          acc_pend = 1'b0;
    bit          new_read = 1'b1;
    int          stall_left = 0;
    int          lat_left = 0;
    int          hold_err = 0;
    logic [15:0] acc_addr = 16'h0000;
    logic [15:0] cur_addr = 16'h0000;
    logic [15:0] acc_q [$];

    logic [15:0] exp_img  [IS];
    logic [15:0] exp_coef [NW];

    function automatic logic [15:0] data_of(input logic [15:0] a);
        return (a - off_cfg) ^ xor_cfg;
    endfunction

    // Memory: stalls each read stall_cfg cycles, returns data lat_cfg cycles
    // after the cycle following acceptance, optionally sprays stray valids.
    always @(negedge clk) begin
        if (!n_reset) begin
            acc_pend          = 1'b0;
            new_read          = 1'b1;
            mem_readdatavalid = 1'b0;
            mem_waitrequest   = 1'b0;
        end else begin
            mem_readdatavalid = 1'b0;
            mem_readdata      = 16'($urandom);
            if (acc_pend) begin
                if (lat_left == 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata      = data_of(acc_addr);
                    acc_pend          = 1'b0;
                end else begin
                    lat_left = lat_left - 1;
                end
            end else if (spur_en && (mem_read || !busy) && ($urandom_range(0, 3) == 0)) begin
                mem_readdatavalid = 1'b1;
            end
            if (mem_read) begin
                if (new_read) begin
                    cur_addr   = mem_address;
                    stall_left = stall_cfg;
                    new_read   = 1'b0;
                end else if (mem_address !== cur_addr) begin
                    hold_err = hold_err + 1;
                end
                if (stall_left > 0) begin
                    mem_waitrequest = 1'b1;
                    stall_left      = stall_left - 1;
                end else begin
                    mem_waitrequest = 1'b0;
                    acc_pend        = 1'b1;
                    acc_addr        = mem_address;
                    lat_left        = lat_cfg;
                    acc_q.push_back(mem_address);
                    new_read        = 1'b1;
                end
            end else begin
                mem_waitrequest = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < IS; i++) exp_img[i] = 16'h0000;
        for (int k = 0; k < NW; k++) exp_coef[k] = 16'h0000;
    endtask

    task automatic check_buses(input string tag);
        int bad_i = 0;
        int bad_c = 0;
        for (int i = 0; i < IS; i++) if (image_data[16*i +: 16] !== exp_img[i]) bad_i++;
        for (int k = 0; k < NW; k++) if (coeff_data[16*k +: 16] !== exp_coef[k]) bad_c++;
        chk({tag, " image_bad_slots"}, bad_i, 0);
        chk({tag, " coeff_bad_slots"}, bad_c, 0);
    endtask

    // One complete load; model updates expectations and checks address order,
    // address hold under stall and final bus contents.
    task automatic run_load(input string tag, input logic [1:0] wd, input logic [9:0] ia,
                            input int st, input int lt, input logic [15:0] off,
                            input logic [15:0] dx, input bit mid,
                            output int reads, output int bcyc);
        logic [15:0] ea [$];
        logic [15:0] base;
        int          start;
        int          h0;
        int          bad;
        stall_cfg = st;
        lat_cfg   = lt;
        off_cfg   = off;
        xor_cfg   = dx;
        start     = acc_q.size();
        h0        = hold_err;
        base      = 16'(int'(ia) * IS);
        if (wd == 2'b00 || wd == 2'b10) begin
            for (int i = 0; i < IS; i++) begin
                ea.push_back(base + 16'(i));
                exp_img[i] = data_of(base + 16'(i));
            end
        end
        if (wd == 2'b01 || wd == 2'b10) begin
            for (int k = 0; k < NW; k++) begin
                ea.push_back(16'h4000 + 16'(k));
                exp_coef[k] = data_of(16'h4000 + 16'(k));
            end
        end
        @(negedge clk);
        get_data      = 1'b1;
        which_data    = wd;
        image_address = ia;
        @(negedge clk);
        get_data      = 1'b0;
        which_data    = 2'($urandom);
        image_address = 10'($urandom);
        bcyc = 0;
        while (busy && bcyc < LIMIT) begin
            bcyc++;
            if (mid && bcyc == 50) begin
                get_data   = 1'b1;
                which_data = 2'b00;
            end else if (mid && bcyc == 51) begin
                get_data = 1'b0;
            end
            @(negedge clk);
        end
        get_data = 1'b0;
        chk({tag, " finished"}, busy, 0);
        reads = acc_q.size() - start;
        bad = 0;
        if (reads != ea.size()) begin
            bad = 1;
        end else begin
            for (int n = 0; n < reads; n++) if (acc_q[start + n] !== ea[n]) bad++;
        end
        chk({tag, " addr_seq_errors"}, bad, 0);
        chk({tag, " addr_hold_errors"}, hold_err - h0, 0);
        check_buses(tag);
    endtask

    typedef struct {
        logic [1:0]  wd;
        logic [9:0]  ia;
        int          st;
        int          lt;
        logic [15:0] off;
        logic [15:0] dx;
        bit          mid;
        int          reads;
        int          bcyc;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int reads;
        int bcyc;
        int c;
        int s;
        tbl[0] = '{2'b00, 10'd3, 0, 0, 16'h0000, 16'h0000, 1'b0, 64,   128};
        tbl[1] = '{2'b00, 10'd3, 3, 0, 16'h0000, 16'h0000, 1'b0, 64,   320};
        tbl[2] = '{2'b01, 10'd3, 0, 0, 16'h4000, 16'h0000, 1'b0, 1024, 2048};
        tbl[3] = '{2'b10, 10'd7, 0, 0, 16'h0000, 16'h5a5a, 1'b1, 1088, 2176};
        clear_model();

        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        repeat (10) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset mem_read", mem_read, 0);
        chk("reset mem_address", mem_address, 0);
        chk("reset image_zero", (image_data == '0), 1);
        chk("reset coeff_zero", (coeff_data == '0), 1);

        for (int r = 0; r < 4; r++) begin
            run_load($sformatf("vec%0d", r), tbl[r].wd, tbl[r].ia, tbl[r].st, tbl[r].lt,
                     tbl[r].off, tbl[r].dx, tbl[r].mid, reads, bcyc);
            chk($sformatf("vec%0d reads", r), reads, tbl[r].reads);
            chk($sformatf("vec%0d busy_cycles", r), bcyc, tbl[r].bcyc);
            if (r < 2) begin
                chk($sformatf("vec%0d image word0", r), image_data[15:0], 192);
                chk($sformatf("vec%0d image word63", r), image_data[63*16 +: 16], 255);
            end else if (r == 2) begin
                chk("vec2 coeff(15,63)", coeff_data[1023*16 +: 16], 1023);
                chk("vec2 coeff(0,1)", coeff_data[1*16 +: 16], 1);
            end
        end

        // reserved encoding must never start a load
        @(negedge clk);
        get_data   = 1'b1;
        which_data = 2'b11;
        @(negedge clk);
        get_data = 1'b0;
        c = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy || mem_read) c++;
            @(negedge clk);
        end
        chk("wd11 busy_cycles", c, 0);

        // reset around word 30 of an image load
        stall_cfg = 0;
        lat_cfg   = 0;
        off_cfg   = 16'h0000;
        xor_cfg   = 16'h1234;
        s = acc_q.size();
        get_data      = 1'b1;
        which_data    = 2'b00;
        image_address = 10'd5;
        @(negedge clk);
        get_data = 1'b0;
        c = 0;
        while (acc_q.size() < s + 30 && c < 1000) begin
            c++;
            @(negedge clk);
        end
        chk("rst_mid reached word 30", (c < 1000), 1);
        n_reset = 1'b0;
        @(negedge clk);
        chk("rst_mid busy", busy, 0);
        chk("rst_mid mem_read", mem_read, 0);
        chk("rst_mid image_zero", (image_data == '0), 1);
        chk("rst_mid coeff_zero", (coeff_data == '0), 1);
        n_reset = 1'b1;
        clear_model();
        run_load("after_rst", 2'b00, 10'd9, 0, 0, 16'h0000, 16'h0000, 1'b0, reads, bcyc);
        chk("after_rst reads", reads, 64);
        chk("after_rst busy_cycles", bcyc, 128);

        // random loads with stalls, latency and stray valids
        spur_en = 1'b1;
        for (int r = 0; r < 4; r++) begin
            logic [1:0] wd;
            int         st;
            int         lt;
            int         nw;
            wd = 2'($urandom_range(0, 2));
            st = $urandom_range(0, 2);
            lt = $urandom_range(0, 1);
            nw = ((wd != 2'b01) ? IS : 0) + ((wd != 2'b00) ? NW : 0);
            run_load($sformatf("rnd%0d", r), wd, 10'($urandom), st, lt, 16'($urandom),
                     16'($urandom), 1'($urandom_range(0, 1)), reads, bcyc);
            chk($sformatf("rnd%0d reads", r), reads, nw);
            chk($sformatf("rnd%0d busy_cycles", r), bcyc, nw * (2 + st + lt));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coef_fetch.md
# coef_fetch

Upstream loader for the ANN top level. On a one-cycle request it reads the input image and/or first-layer weights from external memory one 16-bit word at a time over a single-outstanding read port. It packs the words into the flat image and coefficient buses consumed by the ANN datapath and holds `busy` high for the duration. The falling edge of `busy` is the "image/weights loaded" event the top level already detects.

## Interface
- IMAGE_SIZE, 64: pixels per image (16-bit words).
- FIRST_LAYER, 16: neurons in first layer.
- ADDR_W, 16: memory word-address width.
- IMAGE_BASE, 0: word address of image 0.
- WEIGHT_BASE, 16'h4000: word address of weight[0][0].

Ports:
- clk  in  1  system clock, all state on rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- get_data  in  1  request strobe, sampled only in IDLE.
- which_data  in  2  00 image, 01 weights, 10 image then weights, 11 reserved (ignored).
- image_address  in  10  image index; image base = IMAGE_BASE + image_address*IMAGE_SIZE.
- mem_address  out  ADDR_W  read word address.
- mem_read  out  1  read request.
- mem_waitrequest  in  1  read not accepted this cycle.
- mem_readdatavalid  in  1  mem_readdata valid.
- mem_readdata  in  16  returned word.
- image_data  out  IMAGE_SIZE*16  word i at [16i+15:16i].
- coeff_data  out  FIRST_LAYER*IMAGE_SIZE*16  weight(j,i) at [16(j*IMAGE_SIZE+i) +: 16].
- busy  out  1  load in progress.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: busy=0, mem_read=0. get_data=1 with which_data in {00,01,10} → latch which_data and image base, phase = image (00,10) or weights (01), count=0, go to ISSUE. which_data=11 → stay IDLE.
- ISSUE: busy=1, mem_read=1, mem_address = phase base + count. Stay while mem_waitrequest=1, holding address. On acceptance (waitrequest=0) → WAIT.
- WAIT: mem_read=0. On mem_readdatavalid, write mem_readdata into slot count of the active bus.
  - If count is not the last index of the phase: count+1, go to ISSUE.
  - Last image word with mode 10: phase=weights, count=0, go to ISSUE.
  - Otherwise go to IDLE.
- Weight memory order is neuron-major: address WEIGHT_BASE + j*IMAGE_SIZE + i.
- Counter width is clog2(FIRST_LAYER*IMAGE_SIZE) = 10 bits. Address arithmetic is modulo 2^ADDR_W.
- image_address*IMAGE_SIZE is computed at full width, then truncated to ADDR_W.
- mem_readdatavalid outside WAIT is ignored. get_data while busy is ignored.
- Slots not written by the current load keep their previous contents.

## Timing
- Reset: state IDLE, busy=0, mem_read=0, mem_address=0, count=0, image_data=0, coeff_data=0.
- Reset mid-load aborts immediately; all of the above apply.
- get_data is sampled at edge 0; busy=1 and mem_read=1 from cycle 1.
- Zero-wait memory with readdatavalid one cycle after acceptance costs 2 cycles per word:
  - image: busy high 128 cycles;
  - weights: 2048 cycles;
  - mode 10: 2176 cycles.
- Each waitrequest cycle and each extra data-latency cycle adds one cycle.
- The last word is visible on its bus in the same edge that busy falls. Outputs are stable while busy=0.
- Registered outputs only; no combinational path from mem_* inputs to outputs.

## Structure
- Shared package ann_pkg holds:
  - which_data encodings as an enum (WD_IMAGE, WD_WEIGHTS, WD_BOTH);
  - the FSM state enum;
  - IMAGE_SIZE and FIRST_LAYER defaults shared with the ANN datapath.
- One natural sub-module: coef_read_master, the single-outstanding read handshake (ISSUE/WAIT, waitrequest hold). It returns a word strobe with data to the counter/packer in coef_fetch.

## Test plan
- Reset, then idle 10 cycles → busy=0, mem_read=0, both buses all zero.
- Image load: which_data=00, image_address=3, memory returns data=address, zero wait → addresses 192..255 in order; image_data word 0 = 192, word 63 = 255; busy high exactly 128 cycles.
- Waitrequest stall: same as above with waitrequest=1 for 3 cycles per read → mem_address held constant while stalled; busy high 320 cycles; same data.
- Weights load: which_data=01, data = address − WEIGHT_BASE → coeff_data slot (15,63) = 1023, slot (0,1) = 1; image_data unchanged.
- Mode 10, plus get_data pulsed mid-load, plus which_data=11 in IDLE → exactly 1088 reads; the mid-load request has no effect; the 11 request never asserts busy.
- Assert n_reset at word 30 of an image load → next cycle busy=0, mem_read=0, buses zero; a fresh request afterwards completes normally.
